// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Bundles the hazard_ctrl inputs and outputs. The slave modport
//               is the control unit; the master modport is the pipeline side.
//               HAZARD_CTRL_STEP_EN adds the single-step request i_step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(
    parameter int STALL_CNT_WIDTH = 16
);
    logic                       i_run;
`ifdef HAZARD_CTRL_STEP_EN
    logic                       i_step;
`endif
    logic [4:0]                 i_id_rs;
    logic [4:0]                 i_id_rt;
    logic                       i_id_uses_rt;
    logic                       i_ex_mem_to_reg;
    logic [4:0]                 i_ex_rt;
    logic                       i_ex_halt;
    logic                       i_jump_taken;
    logic                       o_pc_enable;
    logic                       o_if_id_enable;
    logic                       o_if_id_flush;
    logic                       o_id_ex_enable;
    logic                       o_id_ex_flush;
    logic                       o_ex_mem_enable;
    logic                       o_mem_wb_enable;
    logic                       o_halted;
    logic [STALL_CNT_WIDTH-1:0] o_stall_cnt;

    modport master (
        output i_run,
`ifdef HAZARD_CTRL_STEP_EN
        output i_step,
`endif
        output i_id_rs, i_id_rt, i_id_uses_rt, i_ex_mem_to_reg, i_ex_rt,
        output i_ex_halt, i_jump_taken,
        input  o_pc_enable, o_if_id_enable, o_if_id_flush, o_id_ex_enable,
        input  o_id_ex_flush, o_ex_mem_enable, o_mem_wb_enable, o_halted,
        input  o_stall_cnt
    );

    modport slave (
        input  i_run,
`ifdef HAZARD_CTRL_STEP_EN
        input  i_step,
`endif
        input  i_id_rs, i_id_rt, i_id_uses_rt, i_ex_mem_to_reg, i_ex_rt,
        input  i_ex_halt, i_jump_taken,
        output o_pc_enable, o_if_id_enable, o_if_id_flush, o_id_ex_enable,
        output o_id_ex_flush, o_ex_mem_enable, o_mem_wb_enable, o_halted,
        output o_stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline enable/flush control: load-use stalls, jump flushes,
//               halt drain and run/pause gating. Optional single-step input
//               enabled by defining HAZARD_CTRL_STEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int DRAIN_CYCLES    = 2,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  wire           i_clk,
    input  wire           i_reset,
    hazard_ctrl_if.slave  bus
);
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] c_DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [DCW-1:0]             drain_q, drain_d;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic w_lu;
    logic w_active;
    logic w_pc_en, w_ifid_en, w_ifid_fl, w_idex_en, w_idex_fl, w_exmem_en, w_memwb_en;
    logic w_halted;

    // A zero destination is the hardwired zero register and never forwards a hazard.
    assign w_lu = bus.i_ex_mem_to_reg && (bus.i_ex_rt != 5'd0) &&
                  ((bus.i_ex_rt == bus.i_id_rs) ||
                   (bus.i_id_uses_rt && (bus.i_ex_rt == bus.i_id_rt)));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            drain_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        stall_cnt_d = stall_cnt_q;
        w_active    = 1'b0;
        w_pc_en     = 1'b0;
        w_ifid_en   = 1'b0;
        w_ifid_fl   = 1'b0;
        w_idex_en   = 1'b0;
        w_idex_fl   = 1'b0;
        w_exmem_en  = 1'b0;
        w_memwb_en  = 1'b0;
        w_halted    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_run) begin
                    state_d = S_RUN;
                end
`ifdef HAZARD_CTRL_STEP_EN
                else if (bus.i_step) begin
                    w_active = 1'b1;
                end
`endif
            end
            S_RUN: begin
                if (bus.i_run) begin
                    w_active = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                w_idex_en  = 1'b1;
                w_idex_fl  = 1'b1;
                w_exmem_en = 1'b1;
                w_memwb_en = 1'b1;
                if (drain_q == '0) begin
                    state_d = S_HALTED;
                end else begin
                    drain_d = drain_q - DCW'(1);
                end
            end
            default: begin
                w_halted = 1'b1;
            end
        endcase

        // Shared by a RUN cycle and a single-step grant from IDLE.
        if (w_active) begin
            if (bus.i_ex_halt) begin
                w_ifid_en  = 1'b1;
                w_ifid_fl  = 1'b1;
                w_idex_en  = 1'b1;
                w_idex_fl  = 1'b1;
                w_exmem_en = 1'b1;
                w_memwb_en = 1'b1;
                drain_d    = c_DRAIN_LOAD;
                state_d    = S_DRAIN;
            end else if (w_lu) begin
                w_idex_en  = 1'b1;
                w_idex_fl  = 1'b1;
                w_exmem_en = 1'b1;
                w_memwb_en = 1'b1;
                if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
                end
            end else begin
                w_pc_en    = 1'b1;
                w_ifid_en  = 1'b1;
                w_ifid_fl  = bus.i_jump_taken;
                w_idex_en  = 1'b1;
                w_exmem_en = 1'b1;
                w_memwb_en = 1'b1;
            end
        end
    end

    assign bus.o_pc_enable     = w_pc_en;
    assign bus.o_if_id_enable  = w_ifid_en;
    assign bus.o_if_id_flush   = w_ifid_fl;
    assign bus.o_id_ex_enable  = w_idex_en;
    assign bus.o_id_ex_flush   = w_idex_fl;
    assign bus.o_ex_mem_enable = w_exmem_en;
    assign bus.o_mem_wb_enable = w_memwb_en;
    assign bus.o_halted        = w_halted;
    assign bus.o_stall_cnt     = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl (default build
//               and, when HAZARD_CTRL_STEP_EN is defined, single-step).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
    // {pc_en, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, mem_wb_en}
    localparam logic [6:0] c_OFF   = 7'b000_0000;
    localparam logic [6:0] c_NORM  = 7'b110_1011;
    localparam logic [6:0] c_JUMP  = 7'b111_1011;
    localparam logic [6:0] c_STALL = 7'b000_1111;
    localparam logic [6:0] c_HALT  = 7'b011_1111;
    localparam logic [6:0] c_DRAIN = 7'b000_1111;

    logic i_clk = 1'b0;
    logic i_reset;
    int   errors = 0;
    int   checks = 0;

    always #5 i_clk = ~i_clk;

    hazard_ctrl_if #(.STALL_CNT_WIDTH(16)) bus  ();
    hazard_ctrl_if #(.STALL_CNT_WIDTH(2))  bus2 ();

    hazard_ctrl #(.DRAIN_CYCLES(2), .STALL_CNT_WIDTH(16)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    hazard_ctrl #(.DRAIN_CYCLES(1), .STALL_CNT_WIDTH(2)) dut2 (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus2)
    );

    function automatic logic [6:0] outs();
        return {bus.o_pc_enable, bus.o_if_id_enable, bus.o_if_id_flush,
                bus.o_id_ex_enable, bus.o_id_ex_flush, bus.o_ex_mem_enable,
                bus.o_mem_wb_enable};
    endfunction

    function automatic logic [6:0] outs2();
        return {bus2.o_pc_enable, bus2.o_if_id_enable, bus2.o_if_id_flush,
                bus2.o_id_ex_enable, bus2.o_id_ex_flush, bus2.o_ex_mem_enable,
                bus2.o_mem_wb_enable};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_run = 1'b0;           bus2.i_run = 1'b0;
`ifdef HAZARD_CTRL_STEP_EN
        bus.i_step = 1'b0;          bus2.i_step = 1'b0;
`endif
        bus.i_id_rs = 5'd0;         bus2.i_id_rs = 5'd0;
        bus.i_id_rt = 5'd0;         bus2.i_id_rt = 5'd0;
        bus.i_id_uses_rt = 1'b0;    bus2.i_id_uses_rt = 1'b0;
        bus.i_ex_mem_to_reg = 1'b0; bus2.i_ex_mem_to_reg = 1'b0;
        bus.i_ex_rt = 5'd0;         bus2.i_ex_rt = 5'd0;
        bus.i_ex_halt = 1'b0;       bus2.i_ex_halt = 1'b0;
        bus.i_jump_taken = 1'b0;    bus2.i_jump_taken = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (outs() !== c_OFF) begin
            errors++; $display("FAIL reset_outs: got %b want %b", outs(), c_OFF);
        end
        checks++;
        if (bus.o_halted !== 1'b0 || bus.o_stall_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_regs: halted=%b cnt=%0d want 0/0", bus.o_halted, bus.o_stall_cnt);
        end
    endtask

    task automatic test_run();
        bus.i_run = 1'b1;
        #1;
        checks++;
        if (outs() !== c_OFF) begin
            errors++; $display("FAIL run_first_cycle: got %b want %b", outs(), c_OFF);
        end
        tick();
        checks++;
        if (outs() !== c_NORM || bus.o_stall_cnt !== 16'd0) begin
            errors++; $display("FAIL run_normal: got %b cnt=%0d want %b cnt=0", outs(), bus.o_stall_cnt, c_NORM);
        end
    endtask

    task automatic test_lu_rs();
        bus.i_ex_mem_to_reg = 1'b1; bus.i_ex_rt = 5'd5; bus.i_id_rs = 5'd5;
        #1;
        checks++;
        if (outs() !== c_STALL) begin
            errors++; $display("FAIL lu_rs: got %b want %b", outs(), c_STALL);
        end
        tick();
        bus.i_ex_mem_to_reg = 1'b0;
        #1;
        checks++;
        if (bus.o_stall_cnt !== 16'd1 || outs() !== c_NORM) begin
            errors++; $display("FAIL lu_rs_after: cnt=%0d outs=%b want 1 %b", bus.o_stall_cnt, outs(), c_NORM);
        end
        bus.i_ex_mem_to_reg = 1'b1; bus.i_ex_rt = 5'd0; bus.i_id_rs = 5'd0;
        #1;
        checks++;
        if (outs() !== c_NORM) begin
            errors++; $display("FAIL lu_zero_reg: got %b want %b", outs(), c_NORM);
        end
        tick();
        checks++;
        if (bus.o_stall_cnt !== 16'd1) begin
            errors++; $display("FAIL lu_zero_cnt: got %0d want 1", bus.o_stall_cnt);
        end
        bus.i_ex_mem_to_reg = 1'b0;
    endtask

    task automatic test_lu_rt();
        bus.i_ex_mem_to_reg = 1'b1; bus.i_ex_rt = 5'd7; bus.i_id_rt = 5'd7;
        bus.i_id_rs = 5'd3; bus.i_id_uses_rt = 1'b1;
        #1;
        checks++;
        if (outs() !== c_STALL) begin
            errors++; $display("FAIL lu_rt: got %b want %b", outs(), c_STALL);
        end
        tick();
        checks++;
        if (bus.o_stall_cnt !== 16'd2) begin
            errors++; $display("FAIL lu_rt_cnt: got %0d want 2", bus.o_stall_cnt);
        end
        bus.i_id_uses_rt = 1'b0;
        #1;
        checks++;
        if (outs() !== c_NORM) begin
            errors++; $display("FAIL lu_rt_unused: got %b want %b", outs(), c_NORM);
        end
        bus.i_id_uses_rt = 1'b1; bus.i_jump_taken = 1'b1;
        #1;
        checks++;
        if (outs() !== c_STALL) begin
            errors++; $display("FAIL lu_over_jump: got %b want %b", outs(), c_STALL);
        end
        tick();
        bus.i_ex_mem_to_reg = 1'b0;
        #1;
        checks++;
        if (outs() !== c_JUMP || bus.o_stall_cnt !== 16'd3) begin
            errors++; $display("FAIL jump: got %b cnt=%0d want %b cnt=3", outs(), bus.o_stall_cnt, c_JUMP);
        end
        tick();
        bus.i_jump_taken = 1'b0; bus.i_id_uses_rt = 1'b0;
    endtask

    task automatic test_pause();
        bus.i_run = 1'b0;
        #1;
        checks++;
        if (outs() !== c_OFF) begin
            errors++; $display("FAIL pause: got %b want %b", outs(), c_OFF);
        end
        tick();
        bus.i_run = 1'b1;
        #1;
        checks++;
        if (outs() !== c_OFF) begin
            errors++; $display("FAIL pause_idle: got %b want %b", outs(), c_OFF);
        end
        tick();
        checks++;
        if (outs() !== c_NORM) begin
            errors++; $display("FAIL resume: got %b want %b", outs(), c_NORM);
        end
    endtask

    task automatic test_halt();
        bus.i_ex_halt = 1'b1;
        #1;
        checks++;
        if (outs() !== c_HALT) begin
            errors++; $display("FAIL halt_cycle: got %b want %b", outs(), c_HALT);
        end
        tick();
        bus.i_ex_halt = 1'b0; bus.i_run = 1'b0;
        bus.i_ex_mem_to_reg = 1'b1; bus.i_ex_rt = 5'd4; bus.i_id_rs = 5'd4;
        #1;
        checks++;
        if (outs() !== c_DRAIN || bus.o_halted !== 1'b0) begin
            errors++; $display("FAIL drain1: got %b h=%b want %b h=0", outs(), bus.o_halted, c_DRAIN);
        end
        tick();
        bus.i_run = 1'b1; bus.i_jump_taken = 1'b1;
        #1;
        checks++;
        if (outs() !== c_DRAIN || bus.o_halted !== 1'b0) begin
            errors++; $display("FAIL drain2: got %b h=%b want %b h=0", outs(), bus.o_halted, c_DRAIN);
        end
        tick();
        checks++;
        if (outs() !== c_OFF || bus.o_halted !== 1'b1 || bus.o_stall_cnt !== 16'd3) begin
            errors++; $display("FAIL halted: got %b h=%b cnt=%0d want %b h=1 cnt=3", outs(), bus.o_halted, bus.o_stall_cnt, c_OFF);
        end
        bus.i_run = 1'b0;
        tick();
        bus.i_run = 1'b1;
        tick();
        checks++;
        if (outs() !== c_OFF || bus.o_halted !== 1'b1) begin
            errors++; $display("FAIL halted_sticky: got %b h=%b want %b h=1", outs(), bus.o_halted, c_OFF);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        bus.i_run = 1'b1;
        tick();
        bus.i_ex_mem_to_reg = 1'b1; bus.i_ex_rt = 5'd9; bus.i_id_rs = 5'd9;
        tick();
        bus.i_ex_mem_to_reg = 1'b0; bus.i_ex_halt = 1'b1;
        tick();
        bus.i_ex_halt = 1'b0;
        #1;
        checks++;
        if (outs() !== c_DRAIN || bus.o_stall_cnt !== 16'd1) begin
            errors++; $display("FAIL pre_reset_drain: got %b cnt=%0d want %b cnt=1", outs(), bus.o_stall_cnt, c_DRAIN);
        end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        #1;
        checks++;
        if (outs() !== c_OFF || bus.o_halted !== 1'b0 || bus.o_stall_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_mid_drain: got %b h=%b cnt=%0d want %b h=0 cnt=0", outs(), bus.o_halted, bus.o_stall_cnt, c_OFF);
        end
        tick();
        checks++;
        if (outs() !== c_NORM) begin
            errors++; $display("FAIL reset_then_run: got %b want %b", outs(), c_NORM);
        end
    endtask

    task automatic test_saturate_and_short_drain();
        logic [1:0] exp_cnt [4];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3;
        do_reset();
        bus2.i_run = 1'b1;
        tick();
        bus2.i_ex_mem_to_reg = 1'b1; bus2.i_ex_rt = 5'd2; bus2.i_id_rs = 5'd2;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (bus2.o_stall_cnt !== exp_cnt[k]) begin
                errors++; $display("FAIL sat_cnt%0d: got %0d want %0d", k, bus2.o_stall_cnt, exp_cnt[k]);
            end
        end
        bus2.i_ex_mem_to_reg = 1'b0; bus2.i_ex_halt = 1'b1;
        tick();
        bus2.i_ex_halt = 1'b0;
        #1;
        checks++;
        if (outs2() !== c_DRAIN || bus2.o_halted !== 1'b0) begin
            errors++; $display("FAIL drain_one: got %b h=%b want %b h=0", outs2(), bus2.o_halted, c_DRAIN);
        end
        tick();
        checks++;
        if (outs2() !== c_OFF || bus2.o_halted !== 1'b1) begin
            errors++; $display("FAIL drain_one_halted: got %b h=%b want %b h=1", outs2(), bus2.o_halted, c_OFF);
        end
    endtask

`ifdef HAZARD_CTRL_STEP_EN
    task automatic test_step();
        do_reset();
        bus.i_step = 1'b1;
        #1;
        checks++;
        if (outs() !== c_NORM) begin
            errors++; $display("FAIL step_grant: got %b want %b", outs(), c_NORM);
        end
        tick();
        bus.i_step = 1'b0;
        #1;
        checks++;
        if (outs() !== c_OFF) begin
            errors++; $display("FAIL step_release: got %b want %b", outs(), c_OFF);
        end
        tick();
        bus.i_step = 1'b1;
        bus.i_ex_mem_to_reg = 1'b1; bus.i_ex_rt = 5'd6; bus.i_id_rs = 5'd6;
        #1;
        checks++;
        if (outs() !== c_STALL) begin
            errors++; $display("FAIL step_lu: got %b want %b", outs(), c_STALL);
        end
        tick();
        bus.i_ex_mem_to_reg = 1'b0;
        #1;
        checks++;
        if (outs() !== c_NORM || bus.o_stall_cnt !== 16'd1) begin
            errors++; $display("FAIL step_held: got %b cnt=%0d want %b cnt=1", outs(), bus.o_stall_cnt, c_NORM);
        end
        bus.i_step = 1'b0;
    endtask
`endif

    initial begin
        clear_inputs();
        i_reset = 1'b0;
        test_reset();
        test_run();
        test_lu_rs();
        test_lu_rt();
        test_pause();
        test_halt();
        test_reset_mid_drain();
        test_saturate_and_short_drain();
`ifdef HAZARD_CTRL_STEP_EN
        test_step();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
